// File: rtl/score_pkg.sv
// Shared types and helpers for the drum-hit scoring engine.
// Grade encoding, multiplier width and the score clamp helper.
package score_pkg;

  typedef enum logic [1:0] {
    GRADE_GREAT = 2'd0,
    GRADE_GOOD  = 2'd1,
    GRADE_MISS  = 2'd2,
    GRADE_RSVD  = 2'd3
  } grade_e;

  localparam int MULT_W = 3;

  // Clamp a sign-extended sum into the signed range of a w-bit score (w <= 31).
  function automatic logic signed [31:0] clamp_score(input logic signed [31:0] val,
                                                     input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/score_lane.sv
// One lane of the scoring engine: saturating score, combo, multiplier and event.
// Max-combo tracking is built only when SCORE_TRACKER_MAXCOMBO_EN is defined.
module score_lane
  import score_pkg::*;
#(
  parameter int SCORE_W    = 16,
  parameter int COMBO_W    = 8,
  parameter int GREAT_PTS  = 3,
  parameter int GOOD_PTS   = 1,
  parameter int MISS_PTS   = 1,
  parameter int COMBO_STEP = 4,
  parameter int MULT_MAX   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               freeze,
  input  logic               hit_valid,
  input  logic [1:0]         hit_grade,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [MULT_W-1:0]  mult,
  output logic [COMBO_W-1:0] max_combo,
  output logic               score_evt
);

  grade_e               grade;
  logic                 active;
  int                   pts;
  int                   quot;
  logic signed [SCORE_W:0] sum_w;

  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [MULT_W-1:0]  mult_q, mult_d;
  logic               score_evt_q, score_evt_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    grade   = grade_e'(hit_grade);
    active  = hit_valid && !freeze && (grade != GRADE_RSVD);
    score_d = score_q;
    combo_d = combo_q;
    pts     = 0;

    // The multiplier applied to this hit comes from the registered combo.
    case (grade)
      GRADE_GREAT: pts = GREAT_PTS * int'(mult_q);
      GRADE_GOOD:  pts = GOOD_PTS * int'(mult_q);
      GRADE_MISS:  pts = -MISS_PTS;
      default:     pts = 0;
    endcase

    sum_w = $signed({score_q[SCORE_W-1], score_q}) + (SCORE_W+1)'(pts);

    if (active) begin
      score_d = SCORE_W'(clamp_score(32'(sum_w), SCORE_W));
      if (grade == GRADE_MISS) begin
        combo_d = '0;
      end else if (combo_q != '1) begin
        combo_d = combo_q + COMBO_W'(1);
      end
    end

    score_evt_d = active && (score_d != score_q);

    // Register the multiplier alongside the combo it is derived from.
    quot = int'(combo_d) / COMBO_STEP;
    if (quot >= MULT_MAX - 1) begin
      mult_d = MULT_W'(MULT_MAX);
    end else begin
      mult_d = MULT_W'(quot + 1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q     <= '0;
      combo_q     <= '0;
      mult_q      <= MULT_W'(1);
      score_evt_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      combo_q     <= combo_d;
      mult_q      <= mult_d;
      score_evt_q <= score_evt_d;
    end
  end

`ifdef SCORE_TRACKER_MAXCOMBO_EN
  logic [COMBO_W-1:0] max_combo_q, max_combo_d;

  always_comb begin
    max_combo_d = max_combo_q;
    if (combo_d > max_combo_q) begin
      max_combo_d = combo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_combo_q <= '0;
    end else begin
      max_combo_q <= max_combo_d;
    end
  end

  assign max_combo = max_combo_q;
`else
  assign max_combo = '0;
`endif

  assign score     = score_q;
  assign combo     = combo_q;
  assign mult      = mult_q;
  assign score_evt = score_evt_q;

endmodule

// File: rtl/score_tracker.sv
// Multi-lane scoring engine: one score_lane per player, flat bus slicing only.
// Define SCORE_TRACKER_MAXCOMBO_EN to build the per-lane max-combo records.
module score_tracker
  import score_pkg::*;
#(
  parameter int PLAYERS    = 2,
  parameter int SCORE_W    = 16,
  parameter int COMBO_W    = 8,
  parameter int GREAT_PTS  = 3,
  parameter int GOOD_PTS   = 1,
  parameter int MISS_PTS   = 1,
  parameter int COMBO_STEP = 4,
  parameter int MULT_MAX   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       freeze,
  input  logic [PLAYERS-1:0]         hit_valid,
  input  logic [2*PLAYERS-1:0]       hit_grade,
  output logic [SCORE_W*PLAYERS-1:0] score,
  output logic [COMBO_W*PLAYERS-1:0] combo,
  output logic [MULT_W*PLAYERS-1:0]  mult,
  output logic [COMBO_W*PLAYERS-1:0] max_combo,
  output logic [PLAYERS-1:0]         score_evt
);

  for (genvar i = 0; i < PLAYERS; i++) begin : g_lane
    score_lane #(
      .SCORE_W    (SCORE_W),
      .COMBO_W    (COMBO_W),
      .GREAT_PTS  (GREAT_PTS),
      .GOOD_PTS   (GOOD_PTS),
      .MISS_PTS   (MISS_PTS),
      .COMBO_STEP (COMBO_STEP),
      .MULT_MAX   (MULT_MAX)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .freeze    (freeze),
      .hit_valid (hit_valid[i]),
      .hit_grade (hit_grade[2*i +: 2]),
      .score     (score[SCORE_W*i +: SCORE_W]),
      .combo     (combo[COMBO_W*i +: COMBO_W]),
      .mult      (mult[MULT_W*i +: MULT_W]),
      .max_combo (max_combo[COMBO_W*i +: COMBO_W]),
      .score_evt (score_evt[i])
    );
  end

endmodule
